// File: rtl/mac_tx_pkg.sv
// Shared definitions for the MAC TX path: arbiter state encoding and
// last-word byte-count (mod) encodings used by the arbiter, serializer and RX converter.
package mac_tx_pkg;

  localparam int unsigned ST_WIDTH = 4;

  typedef enum logic [ST_WIDTH-1:0] {
    ST_IDLE = 4'b0001,
    ST_GNT0 = 4'b0010,
    ST_GNT1 = 4'b0100,
    ST_GAP  = 4'b1000
  } state_e;

  localparam logic [1:0] MOD_4B = 2'b00;
  localparam logic [1:0] MOD_1B = 2'b01;
  localparam logic [1:0] MOD_2B = 2'b10;
  localparam logic [1:0] MOD_3B = 2'b11;

endpackage

// File: rtl/mac_tx_frm_cnt.sv
// Wrapping frame counter with increment enable; one instance per arbiter channel.
module mac_tx_frm_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mac_tx_arb.sv
// Frame-granular round-robin arbiter merging two 32-bit frame sources onto the
// MAC TX word stream, with a programmable inter-frame gap and error flags.
module mac_tx_arb
  import mac_tx_pkg::*;
#(
  parameter int unsigned IFG_CYC = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch0_sop,
  input  logic             ch0_eop,
  input  logic             ch0_valid,
  input  logic [1:0]       ch0_mod,
  input  logic [31:0]      ch0_data,
  output logic             ch0_ready,
  input  logic             ch1_sop,
  input  logic             ch1_eop,
  input  logic             ch1_valid,
  input  logic [1:0]       ch1_mod,
  input  logic [31:0]      ch1_data,
  output logic             ch1_ready,
  output logic             mac_tx_sop,
  output logic             mac_tx_eop,
  output logic             mac_tx_valid,
  output logic [1:0]       mac_tx_mod,
  output logic [31:0]      mac_tx_data,
  input  logic             mac_tx_ready,
  output logic [CNT_W-1:0] frm_cnt0,
  output logic [CNT_W-1:0] frm_cnt1,
  output logic             err_drop,
  output logic             err_sop
);

  localparam logic [3:0] GAP_LOAD = (IFG_CYC == 0) ? 4'd0 : 4'(IFG_CYC - 1);

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        in_frame_q, in_frame_d;
  logic        err_drop_q, err_drop_d;
  logic        err_sop_q, err_sop_d;
  logic        inc0, inc1;
  logic        req0, req1;
  logic        g1;
  logic        src_valid, src_sop, src_eop;
  logic [1:0]  src_mod;
  logic [31:0] src_data;

  assign req0      = ch0_valid & ch0_sop;
  assign req1      = ch1_valid & ch1_sop;
  assign g1        = (state_q == ST_GNT1);
  assign src_valid = g1 ? ch1_valid : ch0_valid;
  assign src_sop   = g1 ? ch1_sop   : ch0_sop;
  assign src_eop   = g1 ? ch1_eop   : ch0_eop;
  assign src_mod   = g1 ? ch1_mod   : ch0_mod;
  assign src_data  = g1 ? ch1_data  : ch0_data;

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    gap_cnt_d    = gap_cnt_q;
    in_frame_d   = in_frame_q;
    err_drop_d   = 1'b0;
    err_sop_d    = 1'b0;
    inc0         = 1'b0;
    inc1         = 1'b0;
    ch0_ready    = 1'b0;
    ch1_ready    = 1'b0;
    mac_tx_valid = 1'b0;
    mac_tx_sop   = 1'b0;
    mac_tx_eop   = 1'b0;
    mac_tx_mod   = '0;
    mac_tx_data  = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Stray flush is gated by reset so ready reads 0 while rst_n is held low.
        ch0_ready  = rst_n & ch0_valid & ~ch0_sop;
        ch1_ready  = rst_n & ch1_valid & ~ch1_sop;
        err_drop_d = ch0_ready | ch1_ready;
        in_frame_d = 1'b0;
        if (req0 & (~req1 | last_gnt_q)) begin
          state_d    = ST_GNT0;
          last_gnt_d = 1'b0;
        end else if (req1) begin
          state_d    = ST_GNT1;
          last_gnt_d = 1'b1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        mac_tx_valid = src_valid;
        mac_tx_sop   = src_sop;
        mac_tx_eop   = src_eop;
        mac_tx_mod   = src_mod;
        mac_tx_data  = src_data;
        ch0_ready    = ~g1 & mac_tx_ready;
        ch1_ready    = g1 & mac_tx_ready;
        if (src_valid & mac_tx_ready) begin
          in_frame_d = 1'b1;
          err_sop_d  = src_sop & in_frame_q;
          if (src_eop) begin
            inc0       = ~g1;
            inc1       = g1;
            in_frame_d = 1'b0;
            if (IFG_CYC > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) state_d = ST_IDLE;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      gap_cnt_q  <= '0;
      in_frame_q <= 1'b0;
      err_drop_q <= 1'b0;
      err_sop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gap_cnt_q  <= gap_cnt_d;
      in_frame_q <= in_frame_d;
      err_drop_q <= err_drop_d;
      err_sop_q  <= err_sop_d;
    end
  end

  assign err_drop = err_drop_q;
  assign err_sop  = err_sop_q;

  mac_tx_frm_cnt #(.CNT_W(CNT_W)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc0),
    .cnt   (frm_cnt0)
  );

  mac_tx_frm_cnt #(.CNT_W(CNT_W)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc1),
    .cnt   (frm_cnt1)
  );

endmodule

// File: tb/tb_mac_tx_arb.sv
// Bench for mac_tx_arb: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a frame-level model.
module tb_mac_tx_arb;

  localparam int unsigned IFG = 3;
  localparam int unsigned CW  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ch0_sop, ch0_eop, ch0_valid, ch0_ready;
  logic [1:0]  ch0_mod;
  logic [31:0] ch0_data;
  logic        ch1_sop, ch1_eop, ch1_valid, ch1_ready;
  logic [1:0]  ch1_mod;
  logic [31:0] ch1_data;
  logic        mac_tx_sop, mac_tx_eop, mac_tx_valid, mac_tx_ready;
  logic [1:0]  mac_tx_mod;
  logic [31:0] mac_tx_data;
  logic [CW-1:0] frm_cnt0, frm_cnt1;
  logic        err_drop, err_sop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_tx_arb #(.IFG_CYC(IFG), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_sop(ch0_sop), .ch0_eop(ch0_eop), .ch0_valid(ch0_valid),
    .ch0_mod(ch0_mod), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
    .ch1_sop(ch1_sop), .ch1_eop(ch1_eop), .ch1_valid(ch1_valid),
    .ch1_mod(ch1_mod), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
    .mac_tx_sop(mac_tx_sop), .mac_tx_eop(mac_tx_eop), .mac_tx_valid(mac_tx_valid),
    .mac_tx_mod(mac_tx_mod), .mac_tx_data(mac_tx_data), .mac_tx_ready(mac_tx_ready),
    .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1),
    .err_drop(err_drop), .err_sop(err_sop)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner = channel holding the link (-1 none), gap = idle cycles still owed.
  int   m_owner = -1;
  int   m_gap = 0;
  int   m_last = 1;
  bit   m_inframe = 1'b0;
  int   m_cnt [2] = '{0, 0};
  bit   m_edrop = 1'b0, m_esop = 1'b0;
  bit   xfer [2] = '{1'b0, 1'b0};

  bit          iv [2], is [2], ie [2];
  logic [1:0]  im [2];
  logic [31:0] id [2];
  bit          e_rdy [2];
  bit          e_v, e_s, e_e, x [2], n_edrop, n_esop;
  logic [1:0]  e_m;
  logic [31:0] e_d;

  always @(negedge clk) begin
    iv = '{ch0_valid, ch1_valid}; is = '{ch0_sop, ch1_sop}; ie = '{ch0_eop, ch1_eop};
    im = '{ch0_mod, ch1_mod};     id = '{ch0_data, ch1_data};
    if (!rst_n) begin
      m_owner = -1; m_gap = 0; m_last = 1; m_inframe = 0;
      m_cnt = '{0, 0}; m_edrop = 0; m_esop = 0;
    end
    e_rdy = '{1'b0, 1'b0}; e_v = 0; e_s = 0; e_e = 0; e_m = '0; e_d = '0;
    if (rst_n && m_gap == 0) begin
      if (m_owner < 0) begin
        for (int c = 0; c < 2; c++) e_rdy[c] = iv[c] && !is[c];
      end else begin
        e_v = iv[m_owner]; e_s = is[m_owner]; e_e = ie[m_owner];
        e_m = im[m_owner]; e_d = id[m_owner];
        e_rdy[m_owner] = mac_tx_ready;
      end
    end
    chk("mac_tx_valid", 32'(mac_tx_valid), 32'(e_v));
    chk("mac_tx_sop",   32'(mac_tx_sop),   32'(e_s));
    chk("mac_tx_eop",   32'(mac_tx_eop),   32'(e_e));
    chk("mac_tx_mod",   32'(mac_tx_mod),   32'(e_m));
    chk("mac_tx_data",  mac_tx_data,       e_d);
    chk("ch0_ready",    32'(ch0_ready),    32'(e_rdy[0]));
    chk("ch1_ready",    32'(ch1_ready),    32'(e_rdy[1]));
    chk("frm_cnt0",     32'(frm_cnt0),     32'(m_cnt[0]));
    chk("frm_cnt1",     32'(frm_cnt1),     32'(m_cnt[1]));
    chk("err_drop",     32'(err_drop),     32'(m_edrop));
    chk("err_sop",      32'(err_sop),      32'(m_esop));

    for (int c = 0; c < 2; c++) x[c] = e_rdy[c] && iv[c];
    n_edrop = 0; n_esop = 0;
    if (rst_n) begin
      if (m_gap > 0) m_gap--;
      else if (m_owner < 0) begin
        n_edrop = x[0] || x[1];
        if (iv[0] && is[0] && iv[1] && is[1]) m_owner = 1 - m_last;
        else if (iv[0] && is[0])              m_owner = 0;
        else if (iv[1] && is[1])              m_owner = 1;
        if (m_owner >= 0) begin m_last = m_owner; m_inframe = 0; end
      end else if (x[m_owner]) begin
        if (is[m_owner] && m_inframe) n_esop = 1;
        m_inframe = 1;
        if (ie[m_owner]) begin
          m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
          m_owner = -1;
          m_gap = IFG;
        end
      end
    end
    m_edrop = n_edrop; m_esop = n_esop;
    xfer = x;
  end

  task automatic set_ch(input int c, input bit v, input bit s, input bit e,
                        input logic [1:0] m, input logic [31:0] d);
    if (c == 0) begin ch0_valid = v; ch0_sop = s; ch0_eop = e; ch0_mod = m; ch0_data = d; end
    else        begin ch1_valid = v; ch1_sop = s; ch1_eop = e; ch1_mod = m; ch1_data = d; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Random source drivers: a word is held until it transfers.
  bit          cur_v [2], cur_s [2], cur_e [2], stray [2];
  logic [1:0]  cur_m [2];
  logic [31:0] cur_d [2];
  int          pos [2], len [2];

  task automatic new_word(input int c);
    cur_d[c] = $urandom;
    cur_e[c] = stray[c] ? ($urandom_range(0, 1) == 1) : (pos[c] == len[c] - 1);
    cur_s[c] = stray[c] ? 1'b0 : ((pos[c] == 0) || ($urandom_range(0, 15) == 0));
    cur_m[c] = 2'($urandom_range(0, 3));
  endtask

  task automatic start_frame(input int c);
    pos[c] = 0;
    stray[c] = ($urandom_range(0, 7) == 0);
    len[c] = stray[c] ? 1 : $urandom_range(1, 5);
    cur_v[c] = 0;
    new_word(c);
  endtask

  initial begin
    rst_n = 1'b0; mac_tx_ready = 1'b1;
    set_ch(0, 0, 0, 0, 2'b00, '0); set_ch(1, 0, 0, 0, 2'b00, '0);
    tick(); tick();
    chk("rst_valid", 32'(mac_tx_valid), 32'd0);
    chk("rst_rdy0",  32'(ch0_ready), 32'd0);
    chk("rst_cnt0",  32'(frm_cnt0), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single 3-word ch0 frame, then earliest next grant.
    set_ch(0, 1, 1, 0, 2'b00, 32'hA000_0001); #1;
    chk("sf_req_rdy", 32'(ch0_ready), 32'd0);
    tick(); #1;
    chk("sf_w1_data", mac_tx_data, 32'hA000_0001);
    chk("sf_w1_sop",  32'(mac_tx_sop), 32'd1);
    chk("sf_w1_rdy1", 32'(ch1_ready), 32'd0);
    tick(); set_ch(0, 1, 0, 0, 2'b00, 32'hA000_0002); #1;
    chk("sf_w2_data", mac_tx_data, 32'hA000_0002);
    tick(); set_ch(0, 1, 0, 1, 2'b10, 32'hA000_0003); #1;
    chk("sf_w3_eop", 32'(mac_tx_eop), 32'd1);
    chk("sf_w3_mod", 32'(mac_tx_mod), 32'd2);
    tick(); set_ch(0, 1, 1, 1, 2'b01, 32'hA000_0004); #1;
    chk("sf_cnt_c4", 32'(frm_cnt0), 32'd1);
    chk("sf_gap_v",  32'(mac_tx_valid), 32'd0);
    tick(); tick(); tick(); #1;
    chk("sf_c7_v", 32'(mac_tx_valid), 32'd0);
    tick(); #1;
    chk("sf_c8_v",    32'(mac_tx_valid), 32'd1);
    chk("sf_c8_data", mac_tx_data, 32'hA000_0004);
    tick(); set_ch(0, 0, 0, 0, 2'b00, '0); #1;
    chk("sf_cnt_c9", 32'(frm_cnt0), 32'd2);
    repeat (4) tick();

    // Stray word on ch1 while idle.
    set_ch(1, 1, 0, 0, 2'b00, 32'hE000_0000); #1;
    chk("st_rdy1", 32'(ch1_ready), 32'd1);
    chk("st_v",    32'(mac_tx_valid), 32'd0);
    tick(); set_ch(1, 0, 0, 0, 2'b00, '0); #1;
    chk("st_drop1", 32'(err_drop), 32'd1);
    tick(); #1;
    chk("st_drop0", 32'(err_drop), 32'd0);

    // Mid-frame sop on word 2 of ch0.
    set_ch(0, 1, 1, 0, 2'b00, 32'hF000_0001);
    tick(); tick(); set_ch(0, 1, 1, 0, 2'b00, 32'hF000_0002); #1;
    chk("ms_w2_sop", 32'(mac_tx_sop), 32'd1);
    tick(); set_ch(0, 1, 0, 1, 2'b00, 32'hF000_0003); #1;
    chk("ms_err", 32'(err_sop), 32'd1);
    chk("ms_hold", 32'(mac_tx_valid), 32'd1);
    tick(); set_ch(0, 0, 0, 0, 2'b00, '0); #1;
    chk("ms_err0", 32'(err_sop), 32'd0);
    chk("ms_cnt",  32'(frm_cnt0), 32'd3);

    // Tie right after reset: ch0 first, then ch1.
    tick(); rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    chk("tie_rst_cnt", 32'(frm_cnt0), 32'd0);
    tick();
    set_ch(0, 1, 1, 1, 2'b00, 32'h6000_0000); set_ch(1, 1, 1, 1, 2'b00, 32'h7000_0000);
    tick(); #1;
    chk("tie_first", mac_tx_data, 32'h6000_0000);
    tick(); set_ch(0, 0, 0, 0, 2'b00, '0);
    repeat (4) tick(); #1;
    chk("tie_second", mac_tx_data, 32'h7000_0000);
    tick(); set_ch(1, 0, 0, 0, 2'b00, '0); #1;
    chk("tie_cnt1", 32'(frm_cnt1), 32'd1);
    repeat (5) tick();

    // Backpressure 1010 during a 4-word ch1 frame.
    set_ch(1, 1, 1, 0, 2'b00, 32'hB000_0000);
    tick();
    for (int k = 0; k < 7; k++) begin
      mac_tx_ready = (k % 2 == 0);
      set_ch(1, 1, (k / 2) == 0, (k / 2) == 3, 2'b11, 32'hB000_0000 + 32'(k / 2)); #1;
      chk("bp_rdy1", 32'(ch1_ready), 32'((k % 2) == 0));
      chk("bp_rdy0", 32'(ch0_ready), 32'd0);
      chk("bp_data", mac_tx_data, 32'hB000_0000 + 32'(k / 2));
      tick();
    end
    mac_tx_ready = 1'b1; set_ch(1, 0, 0, 0, 2'b00, '0); #1;
    chk("bp_cnt1", 32'(frm_cnt1), 32'd2);
    repeat (4) tick();

    // Reset at word 2 of a 5-word ch0 frame, then a ch1 frame.
    set_ch(0, 1, 1, 0, 2'b00, 32'hC000_0001);
    tick(); tick(); set_ch(0, 1, 0, 0, 2'b00, 32'hC000_0002);
    rst_n = 1'b0; #1;
    chk("rm_v",    32'(mac_tx_valid), 32'd0);
    chk("rm_rdy0", 32'(ch0_ready), 32'd0);
    chk("rm_cnt0", 32'(frm_cnt0), 32'd0);
    tick(); rst_n = 1'b1;
    set_ch(0, 0, 0, 0, 2'b00, '0); set_ch(1, 1, 1, 1, 2'b00, 32'hD000_0001);
    tick(); #1;
    chk("rm_gnt1", mac_tx_data, 32'hD000_0001);
    tick(); set_ch(1, 0, 0, 0, 2'b00, '0);
    repeat (5) tick();

    // Randomized traffic.
    start_frame(0); start_frame(1);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
        start_frame(0); start_frame(1);
      end else begin
        for (int c = 0; c < 2; c++) begin
          if (cur_v[c] && xfer[c]) begin
            pos[c]++;
            cur_v[c] = 0;
            if (pos[c] >= len[c]) start_frame(c);
            else                  new_word(c);
          end
        end
      end
      for (int c = 0; c < 2; c++)
        if (!cur_v[c]) cur_v[c] = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 2; c++) set_ch(c, cur_v[c], cur_s[c], cur_e[c], cur_m[c], cur_d[c]);
      mac_tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      tick();
    end

    set_ch(0, 0, 0, 0, 2'b00, '0); set_ch(1, 0, 0, 0, 2'b00, '0);
    rst_n = 1'b1;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
